// File: rtl/out_display_sched.sv
// out_display_sched
//   Arbitrates CPU and debug display requests, converts the granted value to
//   sign/magnitude BCD with a sequential shift-add-3 engine, registers the four
//   Display7 digit codes and holds them for a minimum dwell time.
//
//   Optional feature macro: DISP_SIGNED_EN
//     defined   : value[9:0] is two's complement, digit_n shows the sign (11/10)
//     undefined : value[9:0] is unsigned 0..1023, digit_n shows thousands (1/10)
//
//   Ports
//     clock, reset            system clock; synchronous active-low reset
//     cpu_req, cpu_value      CPU request level and value (bits [9:0] used)
//     dbg_req, dbg_value      debug request level and value (bits [9:0] used)
//     blank                   forces all digit outputs to 10 (dark)
//     cpu_ack, dbg_ack        one-cycle grant pulses
//     busy                    high in CONV or HOLD
//     valid                   high once the first update has been displayed
//     digit_n/h/t/o           Display7 codes: 0-9 digit, 10 blank, 11 minus
//
//   state | meaning
//   IDLE  | waiting for a request; CPU wins over debug
//   CONV  | ten shift-add-3 iterations, then load digits and dwell counter
//   HOLD  | dwell countdown; only the CPU may preempt it
module out_display_sched #(
   parameter int HOLD_CYCLES = 25000000,
   parameter int CNT_W       = 25
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [31:0] cpu_value,
   input  logic        dbg_req,
   input  logic [31:0] dbg_value,
   input  logic        blank,
   output logic        cpu_ack,
   output logic        dbg_ack,
   output logic        busy,
   output logic        valid,
   output logic [3:0]  digit_n,
   output logic [3:0]  digit_h,
   output logic [3:0]  digit_t,
   output logic [3:0]  digit_o
);

   typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

   // a dwell of 0 behaves as 1
   localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 1) ? CNT_W'(HOLD_CYCLES - 1) : '0;

   state_t            state, next_state;
   logic              grant_cpu, grant_dbg, load_digits;
   logic [9:0]        grant_val, grant_mag, mag;
   logic              grant_neg, neg;
   logic [15:0]       bcd, bcd_adj;
   logic [3:0]        iter;
   logic [CNT_W-1:0]  hold_cnt;
   logic [3:0]        dn_q, dh_q, dt_q, do_q;
   logic              unused_bits;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   assign grant_val = grant_cpu ? cpu_value[9:0] : dbg_value[9:0];

`ifdef DISP_SIGNED_EN
   assign grant_neg = grant_val[9];
   assign grant_mag = grant_val[9] ? (~grant_val + 10'd1) : grant_val;
`else
   assign grant_neg = 1'b0;
   assign grant_mag = grant_val;
`endif

   assign bcd_adj = {add3(bcd[15:12]), add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
   assign unused_bits = ^{cpu_value[31:10], dbg_value[31:10], bcd_adj[15]};

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state  = state;
      grant_cpu   = 1'b0;
      grant_dbg   = 1'b0;
      load_digits = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req)      grant_cpu = 1'b1;
            else if (dbg_req) grant_dbg = 1'b1;
            if (cpu_req || dbg_req) next_state = CONV;
         end
         CONV: begin
            if (iter == 4'd10) begin
               load_digits = 1'b1;
               next_state  = HOLD;
            end
         end
         HOLD: begin
            if (cpu_req) begin
               grant_cpu  = 1'b1;
               next_state = CONV;
            end else if (hold_cnt == '0) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cpu_ack  <= 1'b0;
         dbg_ack  <= 1'b0;
         valid    <= 1'b0;
         mag      <= '0;
         neg      <= 1'b0;
         bcd      <= '0;
         iter     <= '0;
         hold_cnt <= '0;
         dn_q     <= 4'd10;
         dh_q     <= 4'd10;
         dt_q     <= 4'd10;
         do_q     <= 4'd10;
      end else begin
         cpu_ack <= grant_cpu;
         dbg_ack <= grant_dbg;
         if (grant_cpu || grant_dbg) begin
            mag  <= grant_mag;
            neg  <= grant_neg;
            bcd  <= '0;
            iter <= '0;
         end else if (state == CONV && iter != 4'd10) begin
            // adjust first, then shift in the next magnitude bit MSB first
            bcd  <= {bcd_adj[14:0], mag[9]};
            mag  <= {mag[8:0], 1'b0};
            iter <= iter + 4'd1;
         end
         if (load_digits) begin
`ifdef DISP_SIGNED_EN
            dn_q <= neg ? 4'd11 : 4'd10;
`else
            dn_q <= (bcd[15:12] == 4'd1) ? 4'd1 : 4'd10;
`endif
            dh_q     <= bcd[11:8];
            dt_q     <= bcd[7:4];
            do_q     <= bcd[3:0];
            valid    <= 1'b1;
            hold_cnt <= HOLD_LOAD;
         end else if (state == HOLD && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
         end
      end
   end

   assign busy    = (state != IDLE);
   assign digit_n = blank ? 4'd10 : dn_q;
   assign digit_h = blank ? 4'd10 : dh_q;
   assign digit_t = blank ? 4'd10 : dt_q;
   assign digit_o = blank ? 4'd10 : do_q;

endmodule

// File: tb/tb_out_display_sched.sv
module tb_out_display_sched;
   localparam int HOLD = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0, dbg_req = 1'b0, blank = 1'b0;
   logic [31:0] cpu_value = '0, dbg_value = '0;
   logic        cpu_ack, dbg_ack, busy, valid;
   logic [3:0]  digit_n, digit_h, digit_t, digit_o;

   out_display_sched #(.HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_value(cpu_value),
      .dbg_req(dbg_req), .dbg_value(dbg_value),
      .blank(blank),
      .cpu_ack(cpu_ack), .dbg_ack(dbg_ack), .busy(busy), .valid(valid),
      .digit_n(digit_n), .digit_h(digit_h), .digit_t(digit_t), .digit_o(digit_o)
   );

   always #5 clock = ~clock;

   int errors = 0, checks = 0, cyc = 0;
   int pend_t = -1;
   logic [15:0] pend_val;

   typedef struct {
      int          value;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs[6];

   task automatic tick;
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] digits();
      return {digit_n, digit_h, digit_t, digit_o};
   endfunction

   // expected codes straight from the value rules: sign/thousands, H, T, O
   function automatic logic [15:0] model(input int v);
      int x, m, n;
      x = v & 1023;
`ifdef DISP_SIGNED_EN
      m = (x >= 512) ? 1024 - x : x;
      n = (x >= 512) ? 11 : 10;
`else
      m = x;
      n = (m >= 1000) ? 1 : 10;
`endif
      return {4'(n), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   // tick, and perform the pending digit check of the random phase when due
   task automatic tick_chk;
      tick();
      if (cpu_ack && dbg_ack) chk("two acks", 2'b11, 2'b01);
      if (cyc == pend_t) begin
         chk("rand digits", digits(), blank ? 16'hAAAA : pend_val);
         chk("rand valid", valid, 1);
      end
   endtask

   initial begin
      int k, bad, last_g, exp_g, use_cpu, v, gap;
`ifdef DISP_SIGNED_EN
      vecs[0] = '{123,   16'hA123};
      vecs[1] = '{'h3FF, 16'hB001};
      vecs[2] = '{'h200, 16'hB512};
      vecs[3] = '{511,   16'hA511};
      vecs[4] = '{0,     16'hA000};
      vecs[5] = '{7,     16'hA007};
`else
      vecs[0] = '{1023,  16'h1023};
      vecs[1] = '{999,   16'hA999};
      vecs[2] = '{512,   16'hA512};
      vecs[3] = '{123,   16'hA123};
      vecs[4] = '{0,     16'hA000};
      vecs[5] = '{7,     16'hA007};
`endif

      // reset
      reset = 1'b0;
      repeat (3) tick();
      chk("reset digits", digits(), 16'hAAAA);
      chk("reset valid", valid, 0);
      chk("reset busy", busy, 0);
      chk("reset acks", {cpu_ack, dbg_ack}, 0);
      reset = 1'b1;
      tick();

      // table vectors through the CPU port
      foreach (vecs[i]) begin
         logic [15:0] prev;
         prev = digits();
         cpu_req = 1'b1;
         cpu_value = 32'(vecs[i].value) | 32'hABC0_0000;
         tick();
         chk("vec ack at G", cpu_ack, 1);
         chk("vec busy at G", busy, 1);
         cpu_req = 1'b0;
         tick();
         chk("vec ack at G+1", cpu_ack, 0);
         repeat (9) tick();
         chk("vec digits at G+10", digits(), prev);
         tick();
         chk("vec digits at G+11", digits(), vecs[i].exp);
         chk("vec valid", valid, 1);
         repeat (3) tick();
         chk("vec busy at G+14", busy, 1);
         tick();
         chk("vec idle at G+15", busy, 0);
      end

      // contention: CPU wins, held debug request waits out the dwell
      cpu_req = 1'b1; cpu_value = 5;
      dbg_req = 1'b1; dbg_value = 42;
      tick();
      chk("contention cpu_ack", cpu_ack, 1);
      chk("contention dbg_ack", dbg_ack, 0);
      cpu_req = 1'b0;
      k = 0;
      do begin
         tick(); k++;
         if (k == 11) chk("contention cpu digits", digits(), 16'hA005);
      end while (!dbg_ack && k < 40);
      chk("contention dbg latency", k, 16);
      dbg_req = 1'b0;
      repeat (11) tick();
      chk("contention dbg digits", digits(), 16'hA042);
      repeat (4) tick();
      chk("contention idle", busy, 0);

      // debug raised in HOLD waits; CPU raised in HOLD cycle 2 preempts
      cpu_req = 1'b1; cpu_value = 300;
      tick();
      cpu_req = 1'b0;
      repeat (11) tick();
      chk("hold first digits", digits(), 16'hA300);
      dbg_req = 1'b1; dbg_value = 58;
      tick();
      chk("hold dbg waits", dbg_ack, 0);
      cpu_req = 1'b1; cpu_value = 9;
      tick();
      chk("hold cpu preempt ack", cpu_ack, 1);
      chk("hold no dbg ack", dbg_ack, 0);
      cpu_req = 1'b0;
      k = 0;
      do begin
         tick(); k++;
         if (k == 11) chk("hold preempt digits", digits(), 16'hA009);
      end while (!dbg_ack && k < 40);
      chk("hold dbg latency", k, 16);
      dbg_req = 1'b0;
      repeat (11) tick();
      chk("hold dbg digits", digits(), 16'hA058);
      repeat (4) tick();

      // blank during conversion of 7
      blank = 1'b1;
      cpu_req = 1'b1; cpu_value = 7;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 0) cpu_req = 1'b0;
         if (digits() !== 16'hAAAA) bad++;
      end
      chk("blank outputs dark", bad, 0);
      blank = 1'b0;
      #1;
      chk("blank release digits", digits(), 16'hA007);

      // reset at G+5 discards the conversion
      cpu_req = 1'b1; cpu_value = 77;
      tick();
      cpu_req = 1'b0;
      repeat (4) tick();
      reset = 1'b0;
      tick();
      chk("midreset digits", digits(), 16'hAAAA);
      chk("midreset valid", valid, 0);
      chk("midreset busy", busy, 0);
      reset = 1'b1;
      repeat (7) tick();
      chk("midreset no update", digits(), 16'hAAAA);
      chk("midreset valid stays", valid, 0);

      // randomized transactions against the timing/value model
      last_g = -1000;
      for (int t = 0; t < 40; t++) begin
         use_cpu = $urandom_range(0, 1);
         v = $urandom;
         blank = ($urandom_range(0, 3) == 0);
         if (use_cpu != 0) begin cpu_req = 1'b1; cpu_value = v; end
         else              begin dbg_req = 1'b1; dbg_value = v; end
         // CPU is accepted in HOLD (from G+12), debug only in IDLE (from G+16)
         exp_g = last_g + ((use_cpu != 0) ? 12 : 16);
         if (exp_g < cyc + 1) exp_g = cyc + 1;
         bad = 0;
         k = 0;
         do begin
            tick_chk(); k++;
            if ((use_cpu != 0) ? dbg_ack : cpu_ack) bad++;
         end while (!((use_cpu != 0) ? cpu_ack : dbg_ack) && k < 60);
         chk("rand wrong ack", bad, 0);
         chk("rand grant edge", cyc, exp_g);
         last_g = cyc;
         pend_t = cyc + 11;
         pend_val = model(v);
         cpu_req = 1'b0;
         dbg_req = 1'b0;
         gap = $urandom_range(0, 14);
         repeat (gap) tick_chk();
      end
      repeat (16) tick_chk();
      chk("rand final idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
